lfsr_26_descrambler: RTL and testbench

LFSR_26_DESCRAMBLER -- requirements
Module: lfsr_26_descrambler

---
 rtl/lfsr_26_descrambler.sv | 151 +++++++++++++++
 tb/tb_lfsr_26_descrambler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/lfsr_26_descrambler.sv
// Self-synchronising descrambler for the x^26 + x^25 + x^21 + x^1 key stream.
// Acquires key history from training bits, verifies it, then free-runs.
module lfsr_26_descrambler #(
   parameter int unsigned VERIFY_LEN = 32,
   parameter int unsigned LOSS_LIMIT = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       din,
   input  logic       train,
   output logic       dout,
   output logic       dout_valid,
   output logic       locked,
   output logic [1:0] state,
   output logic [7:0] err_count
);

   localparam int unsigned MW = (VERIFY_LEN > 1) ? $clog2(VERIFY_LEN + 1) : 1;
   localparam int unsigned LW = (LOSS_LIMIT > 1) ? $clog2(LOSS_LIMIT + 1) : 1;

   typedef enum logic [1:0] {
      HUNT   = 2'b00,
      VERIFY = 2'b01,
      LOCKED = 2'b10
   } state_t;

   state_t        state_q, state_d;
   logic [25:0]   h_q, h_d;
   logic [4:0]    fill_q, fill_d;
   logic [MW-1:0] match_q, match_d;
   logic [LW-1:0] loss_q, loss_d;
   logic [7:0]    err_q, err_d;
   logic          dout_q, dout_d;
   logic          valid_q, valid_d;
   logic          locked_q, locked_d;
   logic          key_in;
   logic          pred;

   // h_q[0] is the newest key bit k[n-1], h_q[25] the oldest k[n-26]
   assign key_in = ~din;
   assign pred   = h_q[25] ^ h_q[24] ^ h_q[20] ^ h_q[0];

   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      fill_d  = fill_q;
      match_d = match_q;
      loss_d  = loss_q;
      err_d   = err_q;
      dout_d  = 1'b0;
      valid_d = 1'b0;
      unique case (state_q)
         HUNT: begin
            match_d = '0;
            loss_d  = '0;
            if (train) begin
               h_d = {h_q[24:0], key_in};
               if (fill_q == 5'd25) begin
                  fill_d  = '0;
                  state_d = VERIFY;
               end else begin
                  fill_d = fill_q + 5'd1;
               end
            end else begin
               fill_d = '0;
            end
         end
         VERIFY: begin
            if (train) begin
               h_d = {h_q[24:0], key_in};
               if (key_in == pred) begin
                  if (match_q == MW'(VERIFY_LEN - 1)) begin
                     match_d = '0;
                     state_d = LOCKED;
                  end else begin
                     match_d = match_q + MW'(1);
                  end
               end else begin
                  match_d = '0;
                  fill_d  = '0;
                  state_d = HUNT;
               end
            end else begin
               match_d = '0;
               fill_d  = '0;
               state_d = HUNT;
            end
         end
         LOCKED: begin
            h_d     = {h_q[24:0], pred};
            dout_d  = ~(din ^ pred);
            valid_d = 1'b1;
            if (train) begin
               if (key_in != pred) begin
                  if (err_q != 8'hFF) err_d = err_q + 8'd1;
                  // The edge that declares loss already presents dout as invalid
                  if (loss_q == LW'(LOSS_LIMIT - 1)) begin
                     loss_d  = '0;
                     fill_d  = '0;
                     state_d = HUNT;
                     dout_d  = 1'b0;
                     valid_d = 1'b0;
                  end else begin
                     loss_d = loss_q + LW'(1);
                  end
               end else begin
                  loss_d = '0;
               end
            end
         end
         default: begin
            state_d = HUNT;
            fill_d  = '0;
            match_d = '0;
            loss_d  = '0;
         end
      endcase
      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= HUNT;
         h_q      <= '0;
         fill_q   <= '0;
         match_q  <= '0;
         loss_q   <= '0;
         err_q    <= '0;
         dout_q   <= 1'b0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         h_q      <= h_d;
         fill_q   <= fill_d;
         match_q  <= match_d;
         loss_q   <= loss_d;
         err_q    <= err_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         locked_q <= locked_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign locked     = locked_q;
   assign state      = state_q;
   assign err_count  = err_q;

endmodule

// File: tb/tb_lfsr_26_descrambler.sv
// Scoreboard bench for lfsr_26_descrambler: a reference key generator drives
// din, expected dout/dout_valid are queued per sample and compared after the edge.
module tb_lfsr_26_descrambler;

   logic       clock;
   logic       reset_n;
   logic       din;
   logic       train;
   logic       dout;
   logic       dout_valid;
   logic       locked;
   logic [1:0] state;
   logic [7:0] err_count;

   int unsigned n_checks;
   int unsigned n_pass;
   bit          kq[$];
   logic [1:0]  exp_q[$];

   lfsr_26_descrambler #(.VERIFY_LEN(32), .LOSS_LIMIT(4)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .din        (din),
      .train      (train),
      .dout       (dout),
      .dout_valid (dout_valid),
      .locked     (locked),
      .state      (state),
      .err_count  (err_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Upstream key: k[0]=0, k[1..25]=1, then the 26-tap recurrence
   function automatic bit next_key();
      int unsigned n;
      bit k;
      n = kq.size();
      if (n < 26) k = (n != 0);
      else k = kq[n-26] ^ kq[n-25] ^ kq[n-21] ^ kq[n-1];
      kq.push_back(k);
      return k;
   endfunction

   // mode 0: no output check, 1: expect descrambled bit valid, 2: expect 0/0
   task automatic drive(input bit plain, input bit trn, input bit flip, input int unsigned mode);
      bit k;
      logic [1:0] e;
      k = next_key();
      din   = ~(plain ^ k) ^ flip;
      train = trn;
      if (mode == 1) exp_q.push_back({plain ^ flip, 1'b1});
      else if (mode == 2) exp_q.push_back(2'b00);
      @(posedge clock);
      #1;
      if (mode != 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq("dout", {31'd0, dout}, {31'd0, e[1]});
         check_eq("dout_valid", {31'd0, dout_valid}, {31'd0, e[0]});
      end
   endtask

   task automatic acquire();
      for (int i = 0; i < 26; i++) begin
         drive(1'b0, 1'b1, 1'b0, 2);
         if (i == 24) check_eq("hunt_before_26", {30'd0, state}, 32'd0);
      end
      check_eq("verify_at_26", {30'd0, state}, 32'd1);
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 1'b1, 1'b0, 2);
         if (i == 30) check_eq("verify_at_57", {30'd0, state}, 32'd1);
      end
      check_eq("locked_state_58", {30'd0, state}, 32'd2);
      check_eq("locked_58", {31'd0, locked}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset_n  = 1'b0;
      din      = 1'b0;
      train    = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_eq("rst_state", {30'd0, state}, 32'd0);
      check_eq("rst_locked", {31'd0, locked}, 32'd0);
      check_eq("rst_dout", {31'd0, dout}, 32'd0);
      check_eq("rst_valid", {31'd0, dout_valid}, 32'd0);
      check_eq("rst_err", {24'd0, err_count}, 32'd0);
      reset_n = 1'b1;

      // Initial acquisition, then 1000 random plaintext bits
      acquire();
      check_eq("err_after_lock", {24'd0, err_count}, 32'd0);
      for (int i = 0; i < 1000; i++) drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1);
      check_eq("still_locked", {31'd0, locked}, 32'd1);

      // Three-bit loss run: counted but not enough to drop lock
      repeat (5) drive(1'b0, 1'b1, 1'b0, 1);
      repeat (3) drive(1'b0, 1'b1, 1'b1, 1);
      repeat (2) drive(1'b0, 1'b1, 1'b0, 1);
      check_eq("err_3", {24'd0, err_count}, 32'd3);
      check_eq("locked_after_3", {31'd0, locked}, 32'd1);

      // Asynchronous reset between edges while locked
      #2 reset_n = 1'b0;
      #1;
      check_eq("async_state", {30'd0, state}, 32'd0);
      check_eq("async_locked", {31'd0, locked}, 32'd0);
      check_eq("async_dout", {31'd0, dout}, 32'd0);
      check_eq("async_valid", {31'd0, dout_valid}, 32'd0);
      check_eq("async_err", {24'd0, err_count}, 32'd0);
      @(posedge clock);
      #1 reset_n = 1'b1;

      // A train=0 gap in HUNT restarts the fill count
      repeat (10) drive(1'b0, 1'b1, 1'b0, 2);
      drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 2);
      acquire();

      // Four-bit loss run drops to HUNT with the error count held
      repeat (3) drive(1'b0, 1'b1, 1'b0, 1);
      repeat (3) drive(1'b0, 1'b1, 1'b1, 1);
      drive(1'b0, 1'b1, 1'b1, 2);
      check_eq("loss_state", {30'd0, state}, 32'd0);
      check_eq("loss_locked", {31'd0, locked}, 32'd0);
      check_eq("loss_err", {24'd0, err_count}, 32'd4);

      // train=0 while in VERIFY returns to HUNT
      repeat (26) drive(1'b0, 1'b1, 1'b0, 2);
      check_eq("verify_again", {30'd0, state}, 32'd1);
      drive(1'b0, 1'b0, 1'b0, 2);
      check_eq("verify_untrain", {30'd0, state}, 32'd0);
      check_eq("err_held", {24'd0, err_count}, 32'd4);

      // Single bad bit at match 20 in VERIFY, then a full re-lock
      repeat (26) drive(1'b0, 1'b1, 1'b0, 2);
      check_eq("verify_c", {30'd0, state}, 32'd1);
      repeat (20) drive(1'b0, 1'b1, 1'b0, 2);
      check_eq("verify_m20", {30'd0, state}, 32'd1);
      drive(1'b0, 1'b1, 1'b1, 2);
      check_eq("verify_miss", {30'd0, state}, 32'd0);
      acquire();

      // 300 mismatches in runs of 3 broken by matches: 4 + 300 saturates
      for (int r = 0; r < 100; r++) begin
         repeat (3) drive(1'b0, 1'b1, 1'b1, 1);
         drive(1'b0, 1'b1, 1'b0, 1);
      end
      check_eq("err_sat", {24'd0, err_count}, 32'd255);
      check_eq("sat_locked", {31'd0, locked}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
